// File: rtl/bus_master_arbiter_if.sv
// bus_master_arbiter_if: requester and bus master port signals shared between the arbiter and its environment
interface bus_master_arbiter_if;
  logic [1:0] r0_instruction;
  logic [7:0] r0_data;
  logic r0_tx_done;
  logic r0_tx_err;
  logic [1:0] r1_instruction;
  logic [7:0] r1_data;
  logic r1_tx_done;
  logic r1_tx_err;
  logic [1:0] m_instruction;
  logic [7:0] m_data_out;
  logic m_tx_done;
  logic [1:0] grant;
  modport master(
    input r0_instruction, r0_data, r1_instruction, r1_data, m_tx_done,
    output r0_tx_done, r0_tx_err, r1_tx_done, r1_tx_err, m_instruction, m_data_out, grant
  );
  modport slave(
    output r0_instruction, r0_data, r1_instruction, r1_data, m_tx_done,
    input r0_tx_done, r0_tx_err, r1_tx_done, r1_tx_err, m_instruction, m_data_out, grant
  );
endinterface

// File: rtl/bus_master_arbiter.sv
// bus_master_arbiter: round-robin sharing of one bus master port between two requesters with a stall watchdog
module bus_master_arbiter #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic reset,
  bus_master_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  state_t state;
  logic [CNT_W-1:0] wd;
  logic last_grant;
  logic owner;
  logic pick;
  logic req0;
  logic req1;
  logic [1:0] g_instr;
  logic [7:0] g_data;
  always_comb begin
    req0 = bus.r0_instruction != 2'b00;
    req1 = bus.r1_instruction != 2'b00;
    pick = (req0 && req1) ? ~last_grant : req1;
    owner = bus.grant[1];
    g_instr = owner ? bus.r1_instruction : bus.r0_instruction;
    g_data = owner ? bus.r1_data : bus.r0_data;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      wd <= '0;
      last_grant <= 1'b1;
      bus.grant <= 2'b00;
      bus.m_instruction <= 2'b00;
      bus.m_data_out <= 8'h00;
      bus.r0_tx_done <= 1'b0;
      bus.r0_tx_err <= 1'b0;
      bus.r1_tx_done <= 1'b0;
      bus.r1_tx_err <= 1'b0;
    end else begin
      bus.r0_tx_done <= 1'b0;
      bus.r0_tx_err <= 1'b0;
      bus.r1_tx_done <= 1'b0;
      bus.r1_tx_err <= 1'b0;
      case (state)
        IDLE: if (req0 || req1) begin
          bus.grant <= pick ? 2'b10 : 2'b01;
          bus.m_instruction <= pick ? bus.r1_instruction : bus.r0_instruction;
          bus.m_data_out <= pick ? bus.r1_data : bus.r0_data;
          wd <= '0;
          state <= BUSY;
        end
        BUSY: if (bus.m_tx_done) begin
          bus.m_instruction <= 2'b00;
          bus.r0_tx_done <= ~owner;
          bus.r1_tx_done <= owner;
          last_grant <= owner;
          state <= RELEASE;
        end else if (wd == WD_LAST) begin
          bus.m_instruction <= 2'b00;
          bus.r0_tx_err <= ~owner;
          bus.r1_tx_err <= owner;
          last_grant <= owner;
          state <= RELEASE;
        end else if (g_instr == 2'b00) begin
          bus.m_instruction <= 2'b00;
          bus.grant <= 2'b00;
          last_grant <= owner;
          state <= IDLE;
        end else begin
          bus.m_instruction <= g_instr;
          bus.m_data_out <= g_data;
          wd <= (wd == '1) ? wd : wd + 1'b1;
        end
        RELEASE: if (g_instr == 2'b00) begin
          bus.grant <= 2'b00;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
